reg_sel: RTL and testbench



---
 rtl/reg_sel_pkg.sv | 25 ++
 rtl/reg_sel_decoder.sv | 17 +
 rtl/reg_sel.sv | 64 ++++++
 tb/tb_reg_sel.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_sel_pkg.sv
// Shared constants, source encodings and idle values for the register-select decoder.
package reg_sel_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_vec_t;

  typedef enum logic [1:0] {
    SRC_USEQ = 2'd0,
    SRC_OP0  = 2'd1,
    SRC_OP1  = 2'd2,
    SRC_OP2  = 2'd3
  } oe_src_e;

  typedef enum logic {
    LSRC_USEQ = 1'b0,
    LSRC_OP0  = 1'b1
  } load_src_e;

  localparam reg_vec_t OES_IDLE      = 8'h00;
  localparam reg_vec_t NOTLOADS_IDLE = 8'hFF;

endpackage

// File: rtl/reg_sel_decoder.sv
// 3-to-8 one-hot decoder with an enable; all-zero output when disabled.
module reg_decoder
  import reg_sel_pkg::*;
(
  input  logic     en,
  input  reg_idx_t idx,
  output reg_vec_t onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_sel.sv
// Registered register-file select: muxes the index sources, decodes them and
// registers one-hot output enables and one-cold load strobes.
module reg_sel
  import reg_sel_pkg::*;
(
  input  logic                 clk,
  input  logic                 notReset,
  input  logic                 oe,
  input  logic                 load,
  input  logic [1:0]           oeSourceSel,
  input  logic                 loadSourceSel,
  input  logic [REG_IDX_W-1:0] useqRegSelOe,
  input  logic [REG_IDX_W-1:0] useqRegSelLoad,
  input  logic [REG_IDX_W-1:0] op0,
  input  logic [REG_IDX_W-1:0] op1,
  input  logic [REG_IDX_W-1:0] op2,
  output logic [NUM_REGS-1:0]  regOes,
  output logic [NUM_REGS-1:0]  regNotLoads
);

  reg_idx_t oe_idx;
  reg_idx_t load_idx;
  reg_vec_t oe_dec;
  reg_vec_t load_dec;

  always_comb begin
    oe_idx = useqRegSelOe;
    case (oe_src_e'(oeSourceSel))
      SRC_USEQ: oe_idx = useqRegSelOe;
      SRC_OP0:  oe_idx = op0;
      SRC_OP1:  oe_idx = op1;
      SRC_OP2:  oe_idx = op2;
      default:  oe_idx = useqRegSelOe;
    endcase
  end

  always_comb begin
    load_idx = (load_src_e'(loadSourceSel) == LSRC_OP0) ? op0 : useqRegSelLoad;
  end

  reg_decoder u_oe_dec (
    .en     (oe),
    .idx    (oe_idx),
    .onehot (oe_dec)
  );

  reg_decoder u_load_dec (
    .en     (load),
    .idx    (load_idx),
    .onehot (load_dec)
  );

  // Single register stage keeps the outputs glitch-free; load strobes are active-low.
  always_ff @(posedge clk) begin
    if (!notReset) begin
      regOes      <= OES_IDLE;
      regNotLoads <= NOTLOADS_IDLE;
    end else begin
      regOes      <= oe_dec;
      regNotLoads <= ~load_dec;
    end
  end

endmodule

// File: tb/tb_reg_sel.sv
// Self-checking bench for reg_sel: directed scenarios, exhaustive index sweeps
// and randomized traffic against an arithmetic reference model.
module tb_reg_sel;

  logic       clk = 1'b0;
  logic       not_reset;
  logic       oe, load;
  logic [1:0] oe_source_sel;
  logic       load_source_sel;
  logic [2:0] useq_oe, useq_load, op0, op1, op2;
  logic [7:0] reg_oes, reg_not_loads;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_sel dut (
    .clk            (clk),
    .notReset       (not_reset),
    .oe             (oe),
    .load           (load),
    .oeSourceSel    (oe_source_sel),
    .loadSourceSel  (load_source_sel),
    .useqRegSelOe   (useq_oe),
    .useqRegSelLoad (useq_load),
    .op0            (op0),
    .op1            (op1),
    .op2            (op2),
    .regOes         (reg_oes),
    .regNotLoads    (reg_not_loads)
  );

  // Reference model: pick the index from a list of candidate sources, then
  // compute the single active bit as a power of two.
  function automatic logic [7:0] model_oes();
    int srcs[4];
    srcs = '{int'(useq_oe), int'(op0), int'(op1), int'(op2)};
    if (!oe) return 8'h00;
    return 8'(2 ** srcs[int'(oe_source_sel)]);
  endfunction

  function automatic logic [7:0] model_not_loads();
    int idx;
    idx = load_source_sel ? int'(op0) : int'(useq_load);
    if (!load) return 8'hFF;
    return 8'(255 - 2 ** idx);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    oe              = 1'($urandom_range(0, 1));
    load            = 1'($urandom_range(0, 1));
    oe_source_sel   = 2'($urandom_range(0, 3));
    load_source_sel = 1'($urandom_range(0, 1));
    useq_oe         = 3'($urandom_range(0, 7));
    useq_load       = 3'($urandom_range(0, 7));
    op0             = 3'($urandom_range(0, 7));
    op1             = 3'($urandom_range(0, 7));
    op2             = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    not_reset = 1'b0;
    oe = 1'b1; load = 1'b1;
    oe_source_sel = 2'd0; load_source_sel = 1'b0;
    useq_oe = 3'd3; useq_load = 3'd4; op0 = 3'd0; op1 = 3'd0; op2 = 3'd0;
    step();
    n_checks++;
    if (reg_oes !== 8'h00) begin
      n_fail++; $display("FAIL reset_oes: got %h expected 00", reg_oes);
    end
    n_checks++;
    if (reg_not_loads !== 8'hFF) begin
      n_fail++; $display("FAIL reset_notloads: got %h expected FF", reg_not_loads);
    end
    not_reset = 1'b1;
  endtask

  task automatic test_oe_sweep();
    logic [7:0] exp_oes[5];
    logic [1:0] sels[5];
    exp_oes = '{8'h04, 8'h02, 8'h08, 8'h80, 8'h04};
    sels    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    oe = 1'b1; load = 1'b1;
    op0 = 3'd1; op1 = 3'd3; op2 = 3'd7;
    useq_oe = 3'd2; useq_load = 3'd0; load_source_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      oe_source_sel = sels[i];
      step();
      n_checks++;
      if (reg_oes !== exp_oes[i]) begin
        n_fail++; $display("FAIL oe_sweep_oes[%0d]: got %h expected %h", i, reg_oes, exp_oes[i]);
      end
      n_checks++;
      if (reg_not_loads !== 8'hFE) begin
        n_fail++; $display("FAIL oe_sweep_notloads[%0d]: got %h expected FE", i, reg_not_loads);
      end
    end
  endtask

  task automatic test_load_source();
    load_source_sel = 1'b1;
    step();
    n_checks++;
    if (reg_not_loads !== 8'hFD) begin
      n_fail++; $display("FAIL load_source_notloads: got %h expected FD", reg_not_loads);
    end
    n_checks++;
    if (reg_oes !== 8'h04) begin
      n_fail++; $display("FAIL load_source_oes: got %h expected 04", reg_oes);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      oe = 1'b0; load = 1'b0;
      step();
      n_checks++;
      if (reg_oes !== 8'h00 || reg_not_loads !== 8'hFF) begin
        n_fail++;
        $display("FAIL idle[%0d]: got oes=%h notloads=%h expected 00/FF", i, reg_oes, reg_not_loads);
      end
    end
  endtask

  task automatic test_overlap();
    oe = 1'b1; load = 1'b1;
    oe_source_sel = 2'd1; load_source_sel = 1'b1; op0 = 3'd5;
    step();
    n_checks++;
    if (reg_oes !== 8'h20 || reg_not_loads !== 8'hDF) begin
      n_fail++;
      $display("FAIL overlap: got oes=%h notloads=%h expected 20/DF", reg_oes, reg_not_loads);
    end
  endtask

  // Every index through every source; the other fields hold random noise.
  task automatic test_exhaustive();
    logic [7:0] e_oes, e_nl;
    for (int src = 0; src < 4; src++) begin
      for (int idx = 0; idx < 8; idx++) begin
        randomize_inputs();
        oe = 1'b1; load = 1'b1;
        oe_source_sel   = 2'(src);
        load_source_sel = 1'(src & 1);
        case (src)
          0: begin useq_oe = 3'(idx); useq_load = 3'(idx); end
          1: op0 = 3'(idx);
          2: begin op1 = 3'(idx); useq_load = 3'(idx); end
          default: begin op2 = 3'(idx); op0 = 3'(7 - idx); end
        endcase
        e_oes = model_oes();
        e_nl  = model_not_loads();
        step();
        n_checks++;
        if (reg_oes !== e_oes || reg_not_loads !== e_nl) begin
          n_fail++;
          $display("FAIL exhaustive src=%0d idx=%0d: got oes=%h notloads=%h expected %h/%h",
                   src, idx, reg_oes, reg_not_loads, e_oes, e_nl);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e_oes, e_nl;
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      e_oes = model_oes();
      e_nl  = model_not_loads();
      step();
      n_checks++;
      if (reg_oes !== e_oes || reg_not_loads !== e_nl) begin
        n_fail++;
        $display("FAIL random[%0d]: got oes=%h notloads=%h expected %h/%h",
                 i, reg_oes, reg_not_loads, e_oes, e_nl);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] e_oes, e_nl;
    randomize_inputs();
    oe = 1'b1; load = 1'b1;
    e_oes = model_oes();
    e_nl  = model_not_loads();
    step();
    n_checks++;
    if (reg_oes !== e_oes || reg_not_loads !== e_nl) begin
      n_fail++;
      $display("FAIL midreset_before: got oes=%h notloads=%h expected %h/%h", reg_oes, reg_not_loads, e_oes, e_nl);
    end
    not_reset = 1'b0;
    step();
    n_checks++;
    if (reg_oes !== 8'h00 || reg_not_loads !== 8'hFF) begin
      n_fail++;
      $display("FAIL midreset_held: got oes=%h notloads=%h expected 00/FF", reg_oes, reg_not_loads);
    end
    not_reset = 1'b1;
    step();
    n_checks++;
    if (reg_oes !== e_oes || reg_not_loads !== e_nl) begin
      n_fail++;
      $display("FAIL midreset_release: got oes=%h notloads=%h expected %h/%h", reg_oes, reg_not_loads, e_oes, e_nl);
    end
  endtask

  initial begin
    test_reset();
    test_oe_sweep();
    test_load_source();
    test_idle();
    test_overlap();
    test_exhaustive();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
